// File: rtl/aes_job_sched_pkg.sv
// Shared types and constants for the AES job scheduler.
// State encoding, frame/timeout defaults and core ready offsets.
package aes_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int DATA_W_DEF    = 128;
  localparam int FRAME_LEN_DEF = 24;
  localparam int TIMEOUT_DEF   = 32;

  localparam int ENC_READY_CYC = 22;
  localparam int DEC_READY_CYC = 23;

endpackage

// File: rtl/aes_job_sched_if.sv
// Handshake bundle of the scheduler: two job requesters, result port,
// core side and status. slave = scheduler, master = environment.
interface aes_job_sched_if #(
  parameter int DATA_W = 128
);

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic              req0_decr;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic              req1_decr;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_id;
  logic [DATA_W-1:0] core_in;
  logic              core_decr;
  logic              core_rst;
  logic              core_ready;
  logic [DATA_W-1:0] core_out;
  logic              busy;
  logic              err_timeout;

  modport slave (
    input  req0_valid, req0_data, req0_decr,
    input  req1_valid, req1_data, req1_decr,
    input  res_ready, core_ready, core_out,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id,
    output core_in, core_decr, core_rst,
    output busy, err_timeout
  );

  modport master (
    output req0_valid, req0_data, req0_decr,
    output req1_valid, req1_data, req1_decr,
    output res_ready, core_ready, core_out,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id,
    input  core_in, core_decr, core_rst,
    input  busy, err_timeout
  );

endinterface

// File: rtl/aes_job_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer = last winner.
// Ports: clk, reset_n, v0/v1 valids, accept strobe, gnt (winning index).
module rr_arb2 (
  input  logic clk,
  input  logic reset_n,
  input  logic v0,
  input  logic v1,
  input  logic accept,
  output logic gnt
);

  logic ptr;

  // On a tie the requester that did not win last time goes first.
  assign gnt = (v0 & v1) ? ~ptr : v1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= 1'b1;
    end else if (accept) begin
      ptr <= gnt;
    end
  end

endmodule

// File: rtl/aes_job_sched.sv
// Round-robin job scheduler/sequencer for the iterative AES round core.
// Ports: clk, reset_n, bus (requesters, result, core, busy/err_timeout).
module aes_job_sched
  import aes_sched_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input logic           clk,
  input logic           reset_n,
  aes_job_sched_if.slave bus
);

  // Abort can never fire before a legal frame could have finished.
  localparam int LIMIT = (TIMEOUT > FRAME_LEN) ? TIMEOUT : FRAME_LEN + 1;
  localparam int CNT_W = $clog2(LIMIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  state_t            state;
  state_t            stateNxt;
  logic [CNT_W-1:0]  cycCnt;
  logic              gntId;
  logic              jobId;
  logic              anyValid;
  logic              bufFree;
  logic              accept;
  logic              capture;
  logic              timeout;
  logic              coreRstQ;
  logic [DATA_W-1:0] coreIn;
  logic              coreDecr;
  logic              resValid;
  logic [DATA_W-1:0] resData;
  logic              resId;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .v0      (bus.req0_valid),
    .v1      (bus.req1_valid),
    .accept  (accept),
    .gnt     (gntId)
  );

  always_comb begin
    anyValid = bus.req0_valid | bus.req1_valid;
    // A result leaving this cycle frees the slot for the next job.
    bufFree  = ~resValid | bus.res_ready;
    accept   = reset_n & (state == IDLE) & anyValid & bufFree;
    capture  = (state == RUN) & bus.core_ready;
    timeout  = (state == RUN) & ~bus.core_ready & (cycCnt == LAST);
  end

  always_comb begin
    stateNxt = state;
    unique case (1'b1)
      (state == IDLE): if (accept) stateNxt = SYNC;
      (state == SYNC): stateNxt = RUN;
      (state == RUN):  if (capture | timeout) stateNxt = IDLE;
      default:         stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cycCnt   <= '0;
      coreRstQ <= 1'b0;
      coreIn   <= '0;
      coreDecr <= 1'b0;
      jobId    <= 1'b0;
      resValid <= 1'b0;
      resData  <= '0;
      resId    <= 1'b0;
    end else begin
      state    <= stateNxt;
      coreRstQ <= accept;
      if (state == SYNC) begin
        cycCnt <= '0;
      end else if (state == RUN) begin
        cycCnt <= cycCnt + CNT_W'(1);
      end
      if (accept) begin
        coreIn   <= gntId ? bus.req1_data : bus.req0_data;
        coreDecr <= gntId ? bus.req1_decr : bus.req0_decr;
        jobId    <= gntId;
      end
      if (capture) begin
        resValid <= 1'b1;
        resData  <= bus.core_out;
        resId    <= jobId;
      end else if (resValid & bus.res_ready) begin
        resValid <= 1'b0;
      end
    end
  end

  assign bus.req0_ready  = accept & ~gntId;
  assign bus.req1_ready  = accept & gntId;
  assign bus.res_valid   = resValid;
  assign bus.res_data    = resData;
  assign bus.res_id      = resId;
  assign bus.core_in     = coreIn;
  assign bus.core_decr   = coreDecr;
  // Core is held in reset for as long as the scheduler is.
  assign bus.core_rst    = ~reset_n | coreRstQ;
  assign bus.busy        = (state != IDLE);
  assign bus.err_timeout = timeout;

endmodule

// File: tb/tb_aes_job_sched.sv
// Directed self-checking bench for aes_job_sched.
// Drives requesters and a core stand-in; checks with immediate asserts.
module tb_aes_job_sched;

  logic clk;
  logic reset_n;
  int   nAsserts;
  int   nFail;

  aes_job_sched_if #(.DATA_W(128)) bus ();

  aes_job_sched dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] D0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] D1 = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] D2 = 128'h0f0e0d0c0b0a09080706050403020100;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.core_ready = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  // Caller raises the valid(s) and waits #1 before calling (cycle 0).
  // Returns in the result cycle without advancing past it.
  task automatic do_job(input bit id, input bit decr,
                        input logic [127:0] din, input logic [127:0] dout,
                        input int readyCyc, input bit hold);
    chk("req_ready", id ? bus.req1_ready : bus.req0_ready, 1'b1);
    chk("req_other", id ? bus.req0_ready : bus.req1_ready, 1'b0);
    tick();
    if (!hold) begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
    #1;
    chk("sync_rst", bus.core_rst, 1'b1);
    chk("sync_busy", bus.busy, 1'b1);
    chk("sync_in", bus.core_in, din);
    chk("sync_decr", bus.core_decr, decr);
    chk("sync_resv", bus.res_valid, 1'b0);
    chk("sync_rdy", bus.req0_ready | bus.req1_ready, 1'b0);
    tick();
    for (int c = 0; c <= readyCyc; c++) begin
      chk("run_rst", bus.core_rst, 1'b0);
      chk("run_in", bus.core_in, din);
      chk("run_decr", bus.core_decr, decr);
      chk("run_busy", bus.busy, 1'b1);
      chk("run_resv", bus.res_valid, 1'b0);
      if (c == readyCyc) begin
        bus.core_ready = 1'b1;
        bus.core_out   = dout;
      end
      tick();
    end
    bus.core_ready = 1'b0;
    bus.core_out   = '0;
    #1;
    chk("res_valid", bus.res_valid, 1'b1);
    chk("res_data", bus.res_data, dout);
    chk("res_id", bus.res_id, id);
    chk("res_busy", bus.busy, 1'b0);
    chk("res_err", bus.err_timeout, 1'b0);
  endtask

  initial begin
    nAsserts = 0;
    nFail = 0;
    reset_n = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req0_decr  = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    bus.req1_decr  = 1'b0;
    bus.res_ready  = 1'b0;
    bus.core_ready = 1'b0;
    bus.core_out   = '0;
    #2;
    reset_n = 1'b0;
    bus.req0_valid = 1'b1;
    #1;
    chk("rst_core_rst", bus.core_rst, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_resv", bus.res_valid, 1'b0);
    chk("rst_rdy0", bus.req0_ready, 1'b0);
    chk("rst_err", bus.err_timeout, 1'b0);
    chk("rst_core_in", bus.core_in, 128'h0);
    do_reset();
    chk("idle_core_rst", bus.core_rst, 1'b0);

    // Encrypt job: result at cycle 25.
    bus.req0_valid = 1'b1;
    bus.req0_data  = D0;
    bus.req0_decr  = 1'b0;
    bus.res_ready  = 1'b1;
    #1;
    do_job(1'b0, 1'b0, D0, D1, 22, 1'b0);
    tick();
    chk("drain1", bus.res_valid, 1'b0);

    // Decrypt job: result at cycle 26.
    bus.req0_valid = 1'b1;
    bus.req0_data  = D2;
    bus.req0_decr  = 1'b1;
    #1;
    do_job(1'b0, 1'b1, D2, D0, 23, 1'b0);
    tick();

    // Both requesters held: fresh pointer gives 0,1,0,1.
    do_reset();
    bus.req0_data  = D0;
    bus.req0_decr  = 1'b0;
    bus.req1_data  = D1;
    bus.req1_decr  = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.res_ready  = 1'b1;
    #1;
    do_job(1'b0, 1'b0, D0, 128'hA0, 22, 1'b1);
    do_job(1'b1, 1'b1, D1, 128'hA1, 23, 1'b1);
    do_job(1'b0, 1'b0, D0, 128'hA2, 22, 1'b1);
    do_job(1'b1, 1'b1, D1, 128'hA3, 23, 1'b1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    chk("rr_idle", bus.busy, 1'b0);

    // Back-pressure on the result port blocks new jobs.
    bus.req0_valid = 1'b1;
    bus.req0_data  = D2;
    bus.req0_decr  = 1'b0;
    #1;
    do_job(1'b0, 1'b0, D2, D1, 22, 1'b0);
    bus.res_ready  = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_data  = D0;
    bus.req1_decr  = 1'b1;
    #1;
    chk("bp_rdy1", bus.req1_ready, 1'b0);
    chk("bp_rdy0", bus.req0_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_resv", bus.res_valid, 1'b1);
      chk("bp_data", bus.res_data, D1);
      chk("bp_rdy", bus.req1_ready, 1'b0);
      chk("bp_busy", bus.busy, 1'b0);
    end
    bus.res_ready = 1'b1;
    #1;
    do_job(1'b1, 1'b1, D0, D2, 23, 1'b0);
    tick();

    // Core never answers: abort at RUN cycle 31.
    bus.req0_valid = 1'b1;
    bus.req0_data  = D1;
    bus.req0_decr  = 1'b0;
    #1;
    chk("to_rdy", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("to_sync", bus.core_rst, 1'b1);
    tick();
    for (int c = 0; c < 32; c++) begin
      chk("to_err", bus.err_timeout, c == 31);
      chk("to_busy", bus.busy, 1'b1);
      tick();
    end
    chk("to_err_end", bus.err_timeout, 1'b0);
    chk("to_idle", bus.busy, 1'b0);
    chk("to_resv", bus.res_valid, 1'b0);
    bus.req1_valid = 1'b1;
    bus.req1_data  = D2;
    bus.req1_decr  = 1'b0;
    #1;
    do_job(1'b1, 1'b0, D2, D0, 22, 1'b0);
    tick();

    // Reset in the middle of a job.
    bus.req0_valid = 1'b1;
    bus.req0_data  = D0;
    bus.req0_decr  = 1'b0;
    #1;
    chk("mr_rdy", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    repeat (10) tick();
    chk("mr_pre_busy", bus.busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mr_core_rst", bus.core_rst, 1'b1);
    chk("mr_busy", bus.busy, 1'b0);
    chk("mr_resv", bus.res_valid, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("mr_rel_rst", bus.core_rst, 1'b0);
    for (int i = 0; i < 30; i++) begin
      bus.core_ready = (i == 20);
      bus.core_out   = D1;
      tick();
      chk("mr_noresv", bus.res_valid, 1'b0);
    end
    bus.core_ready = 1'b0;
    chk("mr_idle", bus.busy, 1'b0);
    bus.req0_valid = 1'b1;
    bus.req0_data  = D2;
    bus.req1_valid = 1'b1;
    bus.req1_data  = D1;
    #1;
    chk("mr_gnt0", bus.req0_ready, 1'b1);
    chk("mr_gnt1", bus.req1_ready, 1'b0);
    tick();
    chk("mr_core_in", bus.core_in, D2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/aes_job_sched.md
Name: aes_job_sched

Overview:
- Two-requester job scheduler and sequencer for the iterative AES round core (128-bit state, 24-cycle frame, one-cycle ready pulse, decrypt select).
- Arbitrates requesters round-robin and resynchronises the core frame counter with a one-cycle core reset per job.
- Holds core input and mode stable for the whole frame, captures the result on the core ready pulse, and returns it with a requester tag through a valid/ready result port.

Parameters:
DATA_W, 128, block width
FRAME_LEN, 24, core frame length in cycles
TIMEOUT, 32, RUN cycles without core_ready before abort (must be > FRAME_LEN)

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 job valid
req0_ready  out  1  requester 0 job accepted this cycle
req0_data  in  DATA_W  requester 0 block
req0_decr  in  1  requester 0 mode, 1 = decrypt
req1_valid / req1_ready / req1_data / req1_decr: same roles for requester 1
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_data  out  DATA_W  result block
res_id  out  1  requester index of result
core_in  out  DATA_W  core block input
core_decr  out  1  core mode select
core_rst  out  1  active-high core reset
core_ready  in  1  core result strobe
core_out  in  DATA_W  core result
busy  out  1  state != IDLE
err_timeout  out  1  one-cycle pulse on abort

Behaviour:
Reset values:
- On reset_n low, asynchronously: state=IDLE, all outputs 0, except core_rst=1 (combinational while reset_n low).
- rr pointer=1, so requester 0 wins the first contest.

States: IDLE, SYNC, RUN.

IDLE:
- req_ready for the granted requester = res buffer empty, or (res_valid & res_ready) this cycle.
- The non-granted requester's req_ready is 0.
- On accept (valid & ready at edge T): register data into core_in, decr into core_decr, id into job_id; update rr pointer to the granted id; go to SYNC.

SYNC (cycle T+1):
- core_rst=1 (registered).
- Next: RUN with cyc_cnt=0.

RUN:
- core_rst=0; core_in and core_decr held constant.
- cyc_cnt increments each cycle, width clog2(TIMEOUT).
- Core counter is 0 in the first RUN cycle.
- Encrypt: core_ready expected at cyc_cnt=FRAME_LEN-2.
- Decrypt: core_ready expected at cyc_cnt=FRAME_LEN-1.
- On core_ready: load res_data=core_out, res_id=job_id, set res_valid; go to IDLE.
- If cyc_cnt==TIMEOUT-1 without core_ready: pulse err_timeout, go to IDLE, no result produced.

Result buffer:
- Single entry.
- res_valid clears on res_valid & res_ready.
- If capture and drain coincide, the new result wins (res_valid stays 1).
- Data is stable while res_valid & !res_ready.

Arbitration:
- Only one requester valid: that requester is granted.
- Both valid: the requester not equal to the pointer is granted.
- Pointer updates only on accept.

Other rules:
- Requester inputs are ignored outside IDLE.
- core_ready outside RUN is ignored.
- Latency, acceptance to res_valid high: encrypt FRAME_LEN+1 cycles (T+25), decrypt FRAME_LEN+2 (T+26).
- reset_n low mid-job: job lost, no result, core held in reset.

Decomposition:
- Shared package aes_sched_pkg:
  - state encoding constants (IDLE=2'd0, SYNC=2'd1, RUN=2'd2)
  - FRAME_LEN/TIMEOUT defaults
  - ready-offset constants ENC_READY_CYC=22, DEC_READY_CYC=23
- One sub-module rr_arb2:
  - combinational grant from two valids plus pointer
  - pointer register updated on an accept strobe
  - same clk/reset_n

Test Plan:
- Reset then req0_valid=1, data=128'h00112233445566778899aabbccddeeff, decr=0, res_ready=1 -> req0_ready at cycle 0; core_rst high cycle 1; core_ready at RUN cyc 22 with core_out=X -> res_valid at cycle 25, res_data=X, res_id=0, busy low cycle 25.
- Same with decr=1, core_ready at RUN cyc 23 -> res_valid at cycle 26; core_decr=1 held across all RUN cycles.
- req0_valid and req1_valid both held high, res_ready=1 -> accepts alternate 0,1,0,1 over four jobs; res_id sequence 0,1,0,1.
- res_ready=0 after first result, req1_valid=1 -> req1_ready stays 0 and res_data stable; raise res_ready -> drain and accept in the same cycle, new job SYNC next cycle.
- core_ready never asserted -> err_timeout pulse at RUN cyc 31, state IDLE, res_valid stays 0, next request accepted.
- reset_n low at RUN cyc 10 -> core_rst=1, busy=0, res_valid=0 immediately; no result after release; first contest granted to req0.
